data_producer: RTL and testbench
================================

DATA_PRODUCER -- requirements
Module: data_producer

Interface
REQ-001 SHALL have parameter EMIT_GAP, default 2: minimum clk_1 cycles between consecutive data_1_en pulses; legal range 2..255.
REQ-002 SHALL have parameter TIMER_LIMIT, default 16'd59: last value emitted in timer mode.
REQ-003 SHALL have port clk_1  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a sequence.
REQ-006 SHALL have port stop  input  1  one-cycle request to abort and return to idle.
REQ-007 SHALL have port prog  input  1  mode, sampled on accepted start: 0 = Fibonacci, 1 = timer.
REQ-008 SHALL have port buffer_full  input  1  FIFO write-side full flag, clk_1 domain, no synchronizer.
REQ-009 SHALL have port data_1_en  output  1  one-cycle pulse; data_1 is valid this cycle.
REQ-010 SHALL have port data_1  output  16  produced value.
REQ-011 SHALL have port busy  output  1  high in RUN and HOLD.
REQ-012 SHALL have port done  output  1  high in DONE.
REQ-013 SHALL have port overflow  output  1  sticky; Fibonacci sequence ended on a 16-bit limit.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, HOLD, DONE.
REQ-015 IDLE->RUN on start; mode latched; sequence index reset; gap counter loaded so the first emit happens on the next eligible cycle.
REQ-016 RUN: gap counter decrements each cycle; at zero, if buffer_full==0, data_1_en=1 with the current value at the next edge, value advances and gap counter reloads to EMIT_GAP-1.
REQ-017 RUN->HOLD when the gap counter is zero and buffer_full==1; no pulse; pending value kept.
REQ-018 HOLD->RUN emit: first cycle with buffer_full==0 issues the pending value at the next edge; no value is ever dropped or repeated.
REQ-019 Fibonacci values: 0,1,1,2,3,5,...; next = a+b computed in 17 bits; when bit 16 of the next term is set after emitting 46368, go to DONE and set overflow.
REQ-020 Timer values: 0,1,...,TIMER_LIMIT, then DONE; overflow unaffected.
REQ-021 data_1 SHALL hold the last emitted value between pulses and in HOLD and DONE; it changes only with a pulse.
REQ-022 stop in any state: next state IDLE, data_1_en=0, data_1 held, overflow cleared; stop and start in the same cycle: stop wins.
REQ-023 start in RUN or HOLD is ignored; start in DONE behaves as in IDLE and clears done and overflow.
REQ-024 data_1_en SHALL never assert in consecutive cycles nor in IDLE or DONE.

Reset
REQ-025 rst high SHALL asynchronously force state IDLE, data_1_en=0, data_1=16'h0000, busy=0, done=0, overflow=0, with all counters at 0.
REQ-026 Reset mid-sequence SHALL discard the pending value; the next start restarts from 0.

Configuration
REQ-027 Macro DATA_PRODUCER_WRAP_EN defined: on reaching the end of a sequence (Fibonacci limit or TIMER_LIMIT), restart at 0 (Fibonacci 0,1) in RUN and never enter DONE; overflow is still set on the Fibonacci limit.
REQ-028 Macro not defined: behaviour per REQ-019/REQ-020, ending in DONE.

Verification
REQ-029 prog=0, start, buffer_full=0, EMIT_GAP=2 -> 25 pulses, 2 cycles apart: 0,1,1,2,3,5,...,28657,46368; then done=1, overflow=1, data_1=46368.
REQ-030 Fibonacci run; buffer_full=1 for 10 cycles once value 3 is pending -> no pulse, busy=1, data_1=2; after release, next pulse carries 3, then 5.
REQ-031 prog=1, TIMER_LIMIT=5 -> pulses 0,1,2,3,4,5; done=1, overflow=0; a new start restarts at 0.
REQ-032 stop after value 8 is emitted, start 3 cycles later -> IDLE with data_1=8 held; then a sequence restarts at 0; start+stop in the same cycle -> stays IDLE.
REQ-033 rst asserted mid-RUN, not on an edge -> outputs 0 immediately; no pulse until the next start.
REQ-034 With DATA_PRODUCER_WRAP_EN, prog=1, TIMER_LIMIT=3 -> 0,1,2,3,0,1,...; done stays 0.

Source files
------------

// File: rtl/data_producer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : data_producer
//  Description : Paced Fibonacci / timer value generator feeding a FIFO write
//                port, with buffer_full back-pressure. Optional macro
//                DATA_PRODUCER_WRAP_EN restarts sequences instead of ending.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_producer #(
    parameter int          EMIT_GAP    = 2,
    parameter logic [15:0] TIMER_LIMIT = 16'd59
) (
    input  logic        clk_1,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        prog,
    input  logic        buffer_full,
    output logic        data_1_en,
    output logic [15:0] data_1,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [7:0] c_gap_reload = 8'(EMIT_GAP - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic        r_mode;
    logic [7:0]  r_gap;
    logic [15:0] r_a;
    logic [16:0] r_b;
    logic        r_fin;
    logic        r_en;
    logic [15:0] r_data;
    logic        r_overflow;
    logic        w_emit;
    logic        w_load;
    logic        w_last;

    // r_a is the value to emit next; r_b is the following Fibonacci term,
    // kept at 17 bits so its carry marks r_a as the final 16-bit term.
    always_comb begin
        w_last = r_mode ? (r_a == TIMER_LIMIT) : r_b[16];
    end

    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // r_fin delays DONE by one cycle so the final pulse never overlaps it.
    always_comb begin
        w_next_state = r_state;
        w_emit       = 1'b0;
        w_load       = 1'b0;
        if (stop) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_next_state = S_RUN;
                        w_load       = 1'b1;
                    end
                end
                S_RUN: begin
                    if (r_fin) begin
                        w_next_state = S_DONE;
                    end else if (r_gap == 8'd0) begin
                        if (!buffer_full) begin
                            w_emit = 1'b1;
                        end else begin
                            w_next_state = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!buffer_full) begin
                        w_emit       = 1'b1;
                        w_next_state = S_RUN;
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            r_mode     <= 1'b0;
            r_gap      <= 8'd0;
            r_a        <= 16'd0;
            r_b        <= 17'd0;
            r_fin      <= 1'b0;
            r_en       <= 1'b0;
            r_data     <= 16'h0000;
            r_overflow <= 1'b0;
        end else begin
            r_en <= w_emit;
            if (w_load) begin
                r_mode     <= prog;
                r_a        <= 16'd0;
                r_b        <= 17'd1;
                r_gap      <= 8'd0;
                r_fin      <= 1'b0;
                r_overflow <= 1'b0;
            end else if (stop) begin
                r_overflow <= 1'b0;
            end else if (w_emit) begin
                r_data <= r_a;
                r_gap  <= c_gap_reload;
                if (w_last) begin
                    if (!r_mode) begin
                        r_overflow <= 1'b1;
                    end
`ifdef DATA_PRODUCER_WRAP_EN
                    r_a <= 16'd0;
                    r_b <= 17'd1;
`else
                    r_fin <= 1'b1;
`endif
                end else if (r_mode) begin
                    r_a <= r_a + 16'd1;
                end else begin
                    r_a <= r_b[15:0];
                    r_b <= {1'b0, r_a} + r_b;
                end
            end else if ((r_state == S_RUN) && (r_gap != 8'd0)) begin
                r_gap <= r_gap - 8'd1;
            end
        end
    end

    assign data_1_en = r_en;
    assign data_1    = r_data;
    assign busy      = (r_state == S_RUN) || (r_state == S_HOLD);
    assign done      = (r_state == S_DONE);
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_data_producer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_data_producer
//  Description : Scoreboard bench for data_producer (Fibonacci, timer, hold,
//                stop, async reset). Honours DATA_PRODUCER_WRAP_EN if defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_producer;

    localparam int          EMIT_GAP = 2;
    localparam logic [15:0] TL       = 16'd5;

    logic        clk_1       = 1'b0;
    logic        rst         = 1'b1;
    logic        start       = 1'b0;
    logic        stop        = 1'b0;
    logic        prog        = 1'b0;
    logic        buffer_full = 1'b0;
    logic        data_1_en;
    logic [15:0] data_1;
    logic        busy;
    logic        done;
    logic        overflow;

    int          n_checks  = 0;
    int          n_errors  = 0;
    logic [15:0] sb[$];
    int          cyc       = 0;
    int          pulse_cnt = 0;
    int          first_cyc = 0;
    int          last_cyc  = 0;
    logic [15:0] last_data = 16'd0;
    logic        prev_en   = 1'b0;
    logic [15:0] mon_exp;

    data_producer #(
        .EMIT_GAP    (EMIT_GAP),
        .TIMER_LIMIT (TL)
    ) dut (
        .clk_1       (clk_1),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .prog        (prog),
        .buffer_full (buffer_full),
        .data_1_en   (data_1_en),
        .data_1      (data_1),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow)
    );

    always #5 clk_1 = ~clk_1;

    // Output monitor: pops the scoreboard on each pulse, checks pulse spacing
    // and that data_1 never moves without a pulse.
    always @(negedge clk_1) begin
        cyc++;
        if (rst) begin
            last_data = 16'd0;
            prev_en   = 1'b0;
        end else begin
            n_checks++;
            if (data_1_en) begin
                if (sb.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_pulse: data_1=%0d, required no pulse", data_1);
                end else begin
                    mon_exp = sb.pop_front();
                    if (data_1 !== mon_exp) begin
                        n_errors++;
                        $display("FAIL pulse_value: got %0d, required %0d", data_1, mon_exp);
                    end
                end
                if (prev_en) begin
                    n_errors++;
                    $display("FAIL back_to_back: pulse in consecutive cycles at cycle %0d", cyc);
                end
                if (pulse_cnt == 0) first_cyc = cyc;
                last_cyc  = cyc;
                pulse_cnt++;
                last_data = data_1;
            end else if (data_1 !== last_data) begin
                n_errors++;
                $display("FAIL data_hold: data_1=%0d without pulse, required %0d", data_1, last_data);
            end
            prev_en = data_1_en;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_1);
        #1;
    endtask

    task automatic pulse_start(input logic p);
        start = 1'b1;
        prog  = p;
        @(negedge clk_1);
        #1;
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk_1);
        #1;
        stop = 1'b0;
    endtask

    task automatic wait_sb_empty(input string name, input int budget);
        int i;
        i = 0;
        while (sb.size() != 0 && i < budget) begin
            @(negedge clk_1);
            #1;
            i++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL %s_timeout: %0d values still pending, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic push_fib(input int count);
        int a, b, t;
        a = 0;
        b = 1;
        for (int k = 0; k < count; k++) begin
            sb.push_back(16'(a));
            t = a + b;
            a = b;
            b = t;
        end
    endtask

    task automatic push_timer();
        for (int k = 0; k <= int'(TL); k++) sb.push_back(16'(k));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_cycles(2);
        n_checks += 5;
        if (data_1_en !== 1'b0) begin n_errors++; $display("FAIL reset_en: got %b, required 0", data_1_en); end
        if (data_1 !== 16'h0000) begin n_errors++; $display("FAIL reset_data: got %0d, required 0", data_1); end
        if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b, required 0", done); end
        if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
        rst = 1'b0;
        wait_cycles(2);
    endtask

    task automatic test_fib_full();
        pulse_cnt = 0;
        push_fib(25);
`ifdef DATA_PRODUCER_WRAP_EN
        sb.push_back(16'd0);
        sb.push_back(16'd1);
`endif
        pulse_start(1'b0);
        wait_sb_empty("fib_full", 300);
`ifdef DATA_PRODUCER_WRAP_EN
        n_checks += 2;
        if (overflow !== 1'b1) begin n_errors++; $display("FAIL fib_wrap_overflow: got %b, required 1", overflow); end
        if (done !== 1'b0) begin n_errors++; $display("FAIL fib_wrap_done: got %b, required 0", done); end
        pulse_stop();
`else
        wait_cycles(2);
        n_checks += 6;
        if (pulse_cnt !== 25) begin n_errors++; $display("FAIL fib_count: got %0d, required 25", pulse_cnt); end
        if (last_cyc - first_cyc !== 24 * EMIT_GAP) begin
            n_errors++;
            $display("FAIL fib_spacing: span %0d cycles, required %0d", last_cyc - first_cyc, 24 * EMIT_GAP);
        end
        if (done !== 1'b1) begin n_errors++; $display("FAIL fib_done: got %b, required 1", done); end
        if (overflow !== 1'b1) begin n_errors++; $display("FAIL fib_overflow: got %b, required 1", overflow); end
        if (data_1 !== 16'd46368) begin n_errors++; $display("FAIL fib_last: got %0d, required 46368", data_1); end
        if (busy !== 1'b0) begin n_errors++; $display("FAIL fib_busy: got %b, required 0", busy); end
`endif
    endtask

    task automatic test_timer();
        push_timer();
`ifdef DATA_PRODUCER_WRAP_EN
        sb.push_back(16'd0);
        sb.push_back(16'd1);
        pulse_start(1'b1);
        wait_sb_empty("timer_wrap", 100);
        n_checks++;
        if (done !== 1'b0) begin n_errors++; $display("FAIL timer_wrap_done: got %b, required 0", done); end
        pulse_stop();
`else
        pulse_start(1'b1);
        wait_sb_empty("timer", 100);
        wait_cycles(2);
        n_checks += 3;
        if (done !== 1'b1) begin n_errors++; $display("FAIL timer_done: got %b, required 1", done); end
        if (overflow !== 1'b0) begin n_errors++; $display("FAIL timer_overflow: got %b, required 0", overflow); end
        if (busy !== 1'b0) begin n_errors++; $display("FAIL timer_busy: got %b, required 0", busy); end
        push_timer();
        pulse_start(1'b1);
        wait_sb_empty("timer_restart", 100);
        wait_cycles(2);
        n_checks++;
        if (done !== 1'b1) begin n_errors++; $display("FAIL timer_restart_done: got %b, required 1", done); end
`endif
    endtask

    task automatic test_hold();
        push_fib(4);
        pulse_start(1'b0);
        wait_sb_empty("hold_pre", 50);
        buffer_full = 1'b1;
        wait_cycles(10);
        n_checks += 2;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL hold_busy: got %b, required 1", busy); end
        if (data_1 !== 16'd2) begin n_errors++; $display("FAIL hold_data: got %0d, required 2", data_1); end
        buffer_full = 1'b0;
        sb.push_back(16'd3);
        sb.push_back(16'd5);
        wait_sb_empty("hold_post", 50);
        pulse_stop();
    endtask

    task automatic test_stop();
        push_fib(7);
        pulse_start(1'b0);
        wait_sb_empty("stop_pre", 50);
        pulse_stop();
        wait_cycles(2);
        n_checks += 4;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL stop_busy: got %b, required 0", busy); end
        if (done !== 1'b0) begin n_errors++; $display("FAIL stop_done: got %b, required 0", done); end
        if (data_1 !== 16'd8) begin n_errors++; $display("FAIL stop_data: got %0d, required 8", data_1); end
        if (overflow !== 1'b0) begin n_errors++; $display("FAIL stop_overflow: got %b, required 0", overflow); end
        push_fib(3);
        pulse_start(1'b0);
        wait_sb_empty("stop_restart", 50);
        pulse_stop();
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk_1);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        wait_cycles(3);
        n_checks += 2;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL start_stop_busy: got %b, required 0", busy); end
        if (data_1 !== 16'd1) begin n_errors++; $display("FAIL start_stop_data: got %0d, required 1", data_1); end
    endtask

    task automatic test_async_reset();
        push_fib(3);
        pulse_start(1'b0);
        wait_sb_empty("areset_pre", 50);
        #2;
        rst = 1'b1;
        #1;
        n_checks += 4;
        if (data_1 !== 16'h0000) begin n_errors++; $display("FAIL areset_data: got %0d, required 0", data_1); end
        if (busy !== 1'b0) begin n_errors++; $display("FAIL areset_busy: got %b, required 0", busy); end
        if (done !== 1'b0) begin n_errors++; $display("FAIL areset_done: got %b, required 0", done); end
        if (data_1_en !== 1'b0) begin n_errors++; $display("FAIL areset_en: got %b, required 0", data_1_en); end
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(10);
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL areset_idle_busy: got %b, required 0", busy); end
        push_fib(2);
        pulse_start(1'b0);
        wait_sb_empty("areset_restart", 50);
        pulse_stop();
    endtask

    initial begin
        test_reset();
        test_fib_full();
        test_timer();
        test_hold();
        test_stop();
        test_async_reset();
        wait_cycles(4);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
